// File: rtl/dmem_pkg.sv
// Shared size encodings and byte-enable helper for the dual-port data memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_t;

   function automatic logic [3:0] be_of(input size_t size, input logic [1:0] lane);
      logic [3:0] be;
      be = '0;
      case (size)
         SZ_BYTE: be = 4'b0001 << lane;
         SZ_HALF: be = 4'b0011 << lane;
         SZ_WORD: be = 4'b1111;
         default: be = '0;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Per-port access decode: legality, word index, byte enables, write replication and load extraction.
module dmem_lane_unit
   import dmem_pkg::*;
#(
   parameter int unsigned   DEPTH_LOG2 = 12,
   parameter logic [31:0]   BASE_ADDR  = 32'h0001_0000
) (
   input  logic [31:0]            dad,
   input  size_t                  size,
   input  logic                   mreq,
   input  logic [31:0]            wdata,
   input  logic [31:0]            rword,
   output logic                   legal,
   output logic                   bad,
   output logic [DEPTH_LOG2-1:0]  idx,
   output logic [3:0]             be,
   output logic [31:0]            wrep,
   output logic [31:0]            rdata
);

   localparam logic [31:0] SPAN = 32'(4) << DEPTH_LOG2;

   logic [31:0] off;
   logic        in_range;
   logic        aligned;
   logic [1:0]  lane;
   logic [31:0] shifted;

   assign lane     = dad[1:0];
   assign off      = dad - BASE_ADDR;
   assign in_range = (dad >= BASE_ADDR) && (off < SPAN);
   assign idx      = off[DEPTH_LOG2+1:2];

   always_comb begin
      aligned = 1'b0;
      case (size)
         SZ_BYTE: aligned = 1'b1;
         SZ_HALF: aligned = (dad[0] == 1'b0);
         SZ_WORD: aligned = (dad[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   assign legal = mreq && in_range && aligned;
   assign bad   = mreq && !legal;
   assign be    = legal ? be_of(size, lane) : 4'b0000;

   always_comb begin
      wrep = wdata;
      case (size)
         SZ_BYTE: wrep = {4{wdata[7:0]}};
         SZ_HALF: wrep = {2{wdata[15:0]}};
         default: wrep = wdata;
      endcase
   end

   assign shifted = rword >> {lane, 3'b000};

   always_comb begin
      rdata = '0;
      if (legal) begin
         case (size)
            SZ_BYTE: rdata = {24'h0, shifted[7:0]};
            SZ_HALF: rdata = {16'h0, shifted[15:0]};
            SZ_WORD: rdata = shifted;
            default: rdata = '0;
         endcase
      end
   end

endmodule

// File: rtl/dual_dmem_responder.sv
// Shared data memory serving the alp and bta MEM-stage ports, with alp->bta forwarding,
// saturating access counters and a sticky first-fault record.
module dual_dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned   DEPTH_LOG2 = 12,
   parameter logic [31:0]   BASE_ADDR  = 32'h0001_0000,
   parameter int unsigned   CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       DAD1,
   input  logic [31:0]       DAD2,
   input  logic [31:0]       DDT_w1,
   input  logic [31:0]       DDT_w2,
   input  logic              mreq1,
   input  logic              mreq2,
   input  logic              WRITE1,
   input  logic              WRITE2,
   input  logic [1:0]        SIZE1,
   input  logic [1:0]        SIZE2,
   output logic [31:0]       DDT_r1,
   output logic [31:0]       DDT_r2,
   output logic              fault,
   output logic [31:0]       fault_addr,
   output logic [CNT_W-1:0]  rd_cnt,
   output logic [CNT_W-1:0]  wr_cnt
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   logic [31:0] mem [DEPTH];

   logic                  legal1, legal2, bad1, bad2;
   logic [DEPTH_LOG2-1:0] idx1, idx2;
   logic [3:0]            be1, be2;
   logic [31:0]           wrep1, wrep2;
   logic [31:0]           rdata1, rdata2;
   logic [31:0]           raw1, raw2;
   logic                  st1, st2, ld1, ld2;

   dmem_lane_unit #(.DEPTH_LOG2(DEPTH_LOG2), .BASE_ADDR(BASE_ADDR)) u_alp (
      .dad   (DAD1),
      .size  (size_t'(SIZE1)),
      .mreq  (mreq1),
      .wdata (DDT_w1),
      .rword (raw1),
      .legal (legal1),
      .bad   (bad1),
      .idx   (idx1),
      .be    (be1),
      .wrep  (wrep1),
      .rdata (rdata1)
   );

   dmem_lane_unit #(.DEPTH_LOG2(DEPTH_LOG2), .BASE_ADDR(BASE_ADDR)) u_bta (
      .dad   (DAD2),
      .size  (size_t'(SIZE2)),
      .mreq  (mreq2),
      .wdata (DDT_w2),
      .rword (raw2),
      .legal (legal2),
      .bad   (bad2),
      .idx   (idx2),
      .be    (be2),
      .wrep  (wrep2),
      .rdata (rdata2)
   );

   assign st1 = legal1 && WRITE1;
   assign st2 = legal2 && WRITE2;
   assign ld1 = legal1 && !WRITE1;
   assign ld2 = legal2 && !WRITE2;

   assign raw1 = mem[idx1];

   // bta is younger than alp, so it observes alp's same-cycle store bytes.
   always_comb begin
      raw2 = mem[idx2];
      if (st1 && (idx1 == idx2)) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be1[i]) raw2[8*i +: 8] = wrep1[8*i +: 8];
         end
      end
   end

   assign DDT_r1 = (rst || !ld1) ? '0 : rdata1;
   assign DDT_r2 = (rst || !ld2) ? '0 : rdata2;

   // bta's byte writes are issued after alp's, so bta wins overlapping lanes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (st1 && be1[i]) mem[idx1][8*i +: 8] <= wrep1[8*i +: 8];
            if (st2 && be2[i]) mem[idx2][8*i +: 8] <= wrep2[8*i +: 8];
         end
      end
   end

   logic [1:0]     n_rd, n_wr;
   logic [CNT_W:0] rd_sum, wr_sum;

   assign n_rd   = {1'b0, ld1} + {1'b0, ld2};
   assign n_wr   = {1'b0, st1} + {1'b0, st2};
   assign rd_sum = {1'b0, rd_cnt} + (CNT_W+1)'(n_rd);
   assign wr_sum = {1'b0, wr_cnt} + (CNT_W+1)'(n_wr);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         rd_cnt <= rd_sum[CNT_W] ? '1 : rd_sum[CNT_W-1:0];
         wr_cnt <= wr_sum[CNT_W] ? '1 : wr_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fault      <= 1'b0;
         fault_addr <= '0;
      end else if (!fault && (bad1 || bad2)) begin
         fault      <= 1'b1;
         fault_addr <= bad1 ? DAD1 : DAD2;
      end
   end

endmodule

// File: tb/tb_dual_dmem_responder.sv
// Directed self-checking bench for dual_dmem_responder, plus a narrow-counter instance for saturation.
module tb_dual_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] DAD1 = '0, DAD2 = '0, DDT_w1 = '0, DDT_w2 = '0;
   logic        mreq1 = 1'b0, mreq2 = 1'b0, WRITE1 = 1'b0, WRITE2 = 1'b0;
   logic [1:0]  SIZE1 = '0, SIZE2 = '0;
   logic [31:0] DDT_r1, DDT_r2, fault_addr;
   logic        fault;
   logic [15:0] rd_cnt, wr_cnt;

   logic [31:0] s_dad = 32'h0001_0000;
   logic        s_mreq = 1'b0;
   logic [31:0] s_r1, s_r2, s_faddr;
   logic        s_fault;
   logic [3:0]  s_rd, s_wr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dual_dmem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0001_0000), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .DAD1(DAD1), .DAD2(DAD2), .DDT_w1(DDT_w1), .DDT_w2(DDT_w2),
      .mreq1(mreq1), .mreq2(mreq2), .WRITE1(WRITE1), .WRITE2(WRITE2),
      .SIZE1(SIZE1), .SIZE2(SIZE2), .DDT_r1(DDT_r1), .DDT_r2(DDT_r2),
      .fault(fault), .fault_addr(fault_addr), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
   );

   dual_dmem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0001_0000), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst),
      .DAD1(s_dad), .DAD2(s_dad), .DDT_w1(32'h0), .DDT_w2(32'h0),
      .mreq1(s_mreq), .mreq2(s_mreq), .WRITE1(1'b0), .WRITE2(1'b0),
      .SIZE1(2'b10), .SIZE2(2'b10), .DDT_r1(s_r1), .DDT_r2(s_r2),
      .fault(s_fault), .fault_addr(s_faddr), .rd_cnt(s_rd), .wr_cnt(s_wr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic p1(input logic m, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d);
      mreq1 = m; WRITE1 = w; SIZE1 = sz; DAD1 = a; DDT_w1 = d;
   endtask

   task automatic p2(input logic m, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d);
      mreq2 = m; WRITE2 = w; SIZE2 = sz; DAD2 = a; DDT_w2 = d;
   endtask

   task automatic idle();
      mreq1 = 1'b0;
      mreq2 = 1'b0;
   endtask

   localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

   initial begin
      // reset
      p2(1, 0, W, 32'h1_0000, 0);
      #2 chk("rst_r2_zero", DDT_r2, 0);
      tick(); tick();
      rst = 1'b0; idle();
      chk("rst_fault", {31'h0, fault}, 0);
      chk("rst_faddr", fault_addr, 0);
      chk("rst_rd", {16'h0, rd_cnt}, 0);
      chk("rst_wr", {16'h0, wr_cnt}, 0);

      // word store then load
      p1(1, 1, W, 32'h1_0010, 32'hDEADBEEF); tick(); idle();
      chk("t1_wr", {16'h0, wr_cnt}, 1);
      p2(1, 0, W, 32'h1_0010, 0);
      #2 chk("t1_lw", DDT_r2, 32'hDEADBEEF);
      tick(); idle();
      chk("t1_rd", {16'h0, rd_cnt}, 1);

      // lanes
      p1(1, 1, W, 32'h1_0020, 0); tick();
      p1(1, 1, B, 32'h1_0021, 32'h0000_00AA); tick();
      p1(1, 0, W, 32'h1_0020, 0); p2(1, 0, B, 32'h1_0021, 0);
      #2 chk("t2_lw", DDT_r1, 32'h0000AA00);
      chk("t2_lb", DDT_r2, 32'h0000_00AA);
      tick();
      p1(1, 0, H, 32'h1_0022, 0); mreq2 = 1'b0;
      #2 chk("t2_lh", DDT_r1, 0);
      tick(); idle();
      chk("t2_rd", {16'h0, rd_cnt}, 4);
      chk("t2_wr", {16'h0, wr_cnt}, 3);

      // same-cycle collisions
      p1(1, 1, W, 32'h1_0030, 32'h11111111); p2(1, 1, H, 32'h1_0030, 32'h0000_2222); tick();
      p1(1, 0, W, 32'h1_0030, 0); mreq2 = 1'b0;
      #2 chk("t3_merge", DDT_r1, 32'h11112222);
      tick();
      p1(1, 1, W, 32'h1_0034, 32'h55); p2(1, 0, W, 32'h1_0034, 0);
      #2 chk("t3_fwd", DDT_r2, 32'h0000_0055);
      tick();
      p1(1, 0, W, 32'h1_0034, 0); p2(1, 1, B, 32'h1_0035, 32'h99);
      #2 chk("t3_nofwd", DDT_r1, 32'h0000_0055);
      tick();
      p1(1, 0, W, 32'h1_0034, 0); mreq2 = 1'b0;
      #2 chk("t3_after", DDT_r1, 32'h0000_9955);
      tick(); idle();
      chk("t3_rd", {16'h0, rd_cnt}, 8);
      chk("t3_wr", {16'h0, wr_cnt}, 7);

      // faults
      p1(1, 1, W, 32'h1_0000, 32'hCAFEF00D); tick();
      p1(1, 0, W, 32'h1_0002, 0); p2(1, 1, W, 32'h0, 32'h12345678);
      #2 chk("t4_bad_r1", DDT_r1, 0);
      tick(); idle();
      chk("t4_fault", {31'h0, fault}, 1);
      chk("t4_faddr", fault_addr, 32'h1_0002);
      chk("t4_rd", {16'h0, rd_cnt}, 8);
      chk("t4_wr", {16'h0, wr_cnt}, 8);
      p1(1, 0, W, 32'h1_0000, 0);
      #2 chk("t4_mem", DDT_r1, 32'hCAFEF00D);
      tick();
      p1(1, 0, B, 32'h5, 0); p2(1, 0, R, 32'h1_0000, 0);
      #2 chk("t4_rsvd_r2", DDT_r2, 0);
      tick(); idle();
      chk("t4_faddr_hold", fault_addr, 32'h1_0002);
      chk("t4_fault_hold", {31'h0, fault}, 1);
      chk("t4_rd2", {16'h0, rd_cnt}, 9);
      chk("t4_wr2", {16'h0, wr_cnt}, 8);

      // reset mid-operation
      p1(1, 1, W, 32'h1_0040, 0); tick();
      rst = 1'b1;
      p1(1, 1, W, 32'h1_0040, 32'h77); p2(1, 0, W, 32'h1_0000, 0);
      #2 chk("t5_r1", DDT_r1, 0);
      chk("t5_r2", DDT_r2, 0);
      tick();
      rst = 1'b0; idle();
      chk("t5_fault", {31'h0, fault}, 0);
      chk("t5_faddr", fault_addr, 0);
      chk("t5_rd", {16'h0, rd_cnt}, 0);
      chk("t5_wr", {16'h0, wr_cnt}, 0);
      p1(1, 0, W, 32'h1_0040, 0);
      #2 chk("t5_nowrite", DDT_r1, 0);
      tick(); idle();
      chk("t5_rd_after", {16'h0, rd_cnt}, 1);

      // saturation on the 4-bit counter instance: 2 loads per cycle
      s_mreq = 1'b1;
      repeat (7) tick();
      chk("t6_rd14", {28'h0, s_rd}, 14);
      tick();
      chk("t6_rd_sat", {28'h0, s_rd}, 15);
      tick(); tick();
      s_mreq = 1'b0;
      chk("t6_rd_hold", {28'h0, s_rd}, 15);
      chk("t6_wr", {28'h0, s_wr}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
